segment_capture: RTL
====================

# segment_capture

Writer side of the LCD segment array. It captures the CPU's multiplexed LCD drive (line select, column bits, active common/H lines) across one video frame and accumulates every segment driven on. On each vblank it publishes a stable `segments[x][y][z]` array to the video path, which indexes it per pixel.

## Interface
Parameters:
- `MAX_X_SEGMENT`, default 9: number of line selects (x in x.y.z).
- `MAX_Y_SEGMENT`, default 16: columns per line (y).
- `MAX_Z_SEGMENT`, default 4: number of commons/H rows (z).
- `PERSIST`, default 1: 1 ORs the previous frame into the published frame (anti-flicker); 0 publishes the current frame only.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `lcd_wr`  in  1  one-cycle strobe; `lcd_line`/`lcd_data`/`lcd_common` valid.
- `lcd_line`  in  4  line select x.
- `lcd_data`  in  MAX_Y_SEGMENT  column bits; bit y drives column y.
- `lcd_common`  in  MAX_Z_SEGMENT  active H rows; normally one-hot.
- `lcd_en`  in  1  CPU LCD enable; low blanks the display.
- `vblank_int`  in  1  video vblank, level.
- `segments`  out  [MAX_Z_SEGMENT-1:0] [MAX_X_SEGMENT][MAX_Y_SEGMENT]  published segment states.
- `frame_done`  out  1  one-cycle pulse when `segments` updates.

## Operation
- Internal state: `acc` (current-frame accumulator), `prev` (last captured frame), `vblank_q` (registered vblank). `acc` and `prev` have the same shape as `segments`.
- State machine with two states:
  - IDLE: entered on reset. Writes are dropped. The first vblank rising edge moves to CAPTURE without publishing and clears `acc`.
  - CAPTURE: normal operation. There is no exit except reset.
- Write in CAPTURE: when `lcd_wr=1`, `lcd_en=1`, and `lcd_line<MAX_X_SEGMENT`, then for every z with `lcd_common[z]=1` and every y: `acc[lcd_line][y][z] |= lcd_data[y]`.
  - Bits are never cleared by writes.
  - A non-one-hot `lcd_common` updates all asserted rows.
  - `lcd_common=0` is a no-op.
  - `lcd_line>=MAX_X_SEGMENT` is ignored.
- Frame edge: an edge exists when `vblank_int=1` and `vblank_q=0`.
- On an edge in CAPTURE, let `m` be `acc` merged with any same-cycle qualifying write. Then:
  - If `lcd_en=1`: `segments <= m | (PERSIST ? prev : 0)`, `prev <= m`.
  - If `lcd_en=0`: `segments <= 0`, `prev <= 0`.
  - In both cases `acc <= 0` and `frame_done <= 1`.
- Between edges, `segments` and `prev` hold. `frame_done` is 0 on every non-edge cycle.

## Timing
- Reset values: `segments`=0, `frame_done`=0, `acc`=0, `prev`=0, state=IDLE, `vblank_q`=1. With `vblank_q`=1, a vblank already high at reset release is not treated as an edge.
- Write latency: a write at cycle t is visible in `segments` at the cycle following the first detected edge at cycle e ≥ t.
- `segments` and `frame_done` change together, registered, one cycle after the edge sample.
- A write on the edge cycle belongs to the frame being published, not to the new `acc`.
- Back-to-back `lcd_wr` on every cycle is supported. There is no backpressure.
- A vblank high for many cycles produces exactly one edge. A vblank low for one cycle followed by a rise produces a new edge.
- Reset asserted mid-frame clears all state immediately (asynchronous). Release returns the block to IDLE.

## Structure
- `segment_pkg`: default `MAX_X_SEGMENT`/`MAX_Y_SEGMENT`/`MAX_Z_SEGMENT` constants and the `capture_state_t` enum (IDLE, CAPTURE). This package is shared with the video segment path.
- Sub-module `segment_accumulator`: owns `acc`. It handles the write decode/OR, the synchronous clear, and presents the merged `m` combinationally.
- Top level: edge detect, state machine, `prev`/`segments` registers, and `frame_done`.

## Test plan
- Reset release with `vblank_int=1`, then hold high: no `frame_done` and `segments`=0. After a fall and a rise: first edge → IDLE→CAPTURE, still no `frame_done`.
- CAPTURE, PERSIST=0: write line 2, data 0x8001, common 0b0100, then an edge → `segments[2][0][2]`=1 and `segments[2][15][2]`=1, all others 0, `frame_done` pulses once. Next edge with no writes → all 0.
- PERSIST=1, same write, then two edges without writes: the segment stays 1 after edge 1 and after edge 2 (via `prev`), and reads 0 after edge 3.
- Write on the exact edge cycle (line 0, data 0x0001, common 0b0001) → appears in that publish. `acc` is empty afterward, so the following frame with no writes publishes 0 (PERSIST=0).
- `lcd_line`=9, data 0xFFFF → no change. Common 0b1111 with line 1, data 0x0010 → `segments[1][4][0..3]` all 1.
- `lcd_en=0` at the edge after valid writes → `segments`=0 and `prev`=0. Writes made while `lcd_en=0` are never published.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared LCD segment array constants and capture state type.
// Also used by the video segment read path.
package segment_pkg;

  localparam int unsigned DefaultMaxXSegment = 9;
  localparam int unsigned DefaultMaxYSegment = 16;
  localparam int unsigned DefaultMaxZSegment = 4;

  typedef enum logic [0:0] {
    IDLE,
    CAPTURE
  } capture_state_t;

endpackage

// File: rtl/segment_accumulator.sv
// Current-frame segment accumulator: ORs qualified writes into acc and
// exposes acc merged with this cycle's write so an edge can publish it.
module segment_accumulator
  import segment_pkg::*;
#(
  parameter int unsigned MAX_X_SEGMENT = DefaultMaxXSegment,
  parameter int unsigned MAX_Y_SEGMENT = DefaultMaxYSegment,
  parameter int unsigned MAX_Z_SEGMENT = DefaultMaxZSegment
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr,
  input  logic [3:0]               line,
  input  logic [MAX_Y_SEGMENT-1:0] data,
  input  logic [MAX_Z_SEGMENT-1:0] common,
  input  logic                     clear,
  output logic [MAX_Z_SEGMENT-1:0] merged [MAX_X_SEGMENT][MAX_Y_SEGMENT]
);

  logic [MAX_Z_SEGMENT-1:0] acc_q [MAX_X_SEGMENT][MAX_Y_SEGMENT];

  // Out-of-range lines match no x and therefore drop out naturally.
  always_comb begin
    for (int unsigned x = 0; x < MAX_X_SEGMENT; x++) begin
      for (int unsigned y = 0; y < MAX_Y_SEGMENT; y++) begin
        merged[x][y] = acc_q[x][y];
        if (wr && (32'(line) == x)) begin
          merged[x][y] = acc_q[x][y] | (common & {MAX_Z_SEGMENT{data[y]}});
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned x = 0; x < MAX_X_SEGMENT; x++) begin
        for (int unsigned y = 0; y < MAX_Y_SEGMENT; y++) begin
          acc_q[x][y] <= '0;
        end
      end
    end else begin
      for (int unsigned x = 0; x < MAX_X_SEGMENT; x++) begin
        for (int unsigned y = 0; y < MAX_Y_SEGMENT; y++) begin
          acc_q[x][y] <= clear ? '0 : merged[x][y];
        end
      end
    end
  end

endmodule

// File: rtl/segment_capture.sv
// Captures multiplexed LCD drive over a frame and publishes a stable
// segment array on each vblank rising edge.
module segment_capture
  import segment_pkg::*;
#(
  parameter int unsigned MAX_X_SEGMENT = DefaultMaxXSegment,
  parameter int unsigned MAX_Y_SEGMENT = DefaultMaxYSegment,
  parameter int unsigned MAX_Z_SEGMENT = DefaultMaxZSegment,
  parameter bit          PERSIST       = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     lcd_wr,
  input  logic [3:0]               lcd_line,
  input  logic [MAX_Y_SEGMENT-1:0] lcd_data,
  input  logic [MAX_Z_SEGMENT-1:0] lcd_common,
  input  logic                     lcd_en,
  input  logic                     vblank_int,
  output logic [MAX_Z_SEGMENT-1:0] segments [MAX_X_SEGMENT][MAX_Y_SEGMENT],
  output logic                     frame_done
);

  capture_state_t state_q, state_d;
  logic vblank_q;
  logic frame_edge;
  logic wr_ok;
  logic acc_clear;
  logic publish;

  logic [MAX_Z_SEGMENT-1:0] acc_m [MAX_X_SEGMENT][MAX_Y_SEGMENT];
  logic [MAX_Z_SEGMENT-1:0] prev_q [MAX_X_SEGMENT][MAX_Y_SEGMENT];
  logic [MAX_Z_SEGMENT-1:0] seg_q [MAX_X_SEGMENT][MAX_Y_SEGMENT];

  // vblank_q resets high so a vblank already asserted at release is not an edge.
  assign frame_edge = vblank_int & ~vblank_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && frame_edge) begin
      state_d = CAPTURE;
    end
  end

  always_comb begin
    wr_ok     = 1'b0;
    publish   = 1'b0;
    acc_clear = frame_edge;
    unique case (state_q)
      IDLE: ;
      CAPTURE: begin
        wr_ok   = lcd_wr & lcd_en;
        publish = frame_edge;
      end
      default: ;
    endcase
  end

  segment_accumulator #(
    .MAX_X_SEGMENT(MAX_X_SEGMENT),
    .MAX_Y_SEGMENT(MAX_Y_SEGMENT),
    .MAX_Z_SEGMENT(MAX_Z_SEGMENT)
  ) u_acc (
    .clk    (clk),
    .reset_n(reset_n),
    .wr     (wr_ok),
    .line   (lcd_line),
    .data   (lcd_data),
    .common (lcd_common),
    .clear  (acc_clear),
    .merged (acc_m)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q   <= 1'b1;
      frame_done <= 1'b0;
      for (int unsigned x = 0; x < MAX_X_SEGMENT; x++) begin
        for (int unsigned y = 0; y < MAX_Y_SEGMENT; y++) begin
          prev_q[x][y] <= '0;
          seg_q[x][y]  <= '0;
        end
      end
    end else begin
      vblank_q   <= vblank_int;
      frame_done <= publish;
      if (publish) begin
        for (int unsigned x = 0; x < MAX_X_SEGMENT; x++) begin
          for (int unsigned y = 0; y < MAX_Y_SEGMENT; y++) begin
            if (lcd_en) begin
              seg_q[x][y]  <= PERSIST ? (acc_m[x][y] | prev_q[x][y]) : acc_m[x][y];
              prev_q[x][y] <= acc_m[x][y];
            end else begin
              seg_q[x][y]  <= '0;
              prev_q[x][y] <= '0;
            end
          end
        end
      end
    end
  end

  assign segments = seg_q;

endmodule
